// File: rtl/decompress_ctrl.sv
// Polynomial decompression controller: unpacks 256 d-bit LSB-first coefficients and streams them decompressed.
// Optional raw-coefficient path enabled by `define DECOMPRESS_CTRL_BYPASS_EN (adds i_bypass).
module decompress_ctrl #(
  parameter int unsigned Q    = 3329,
  parameter int unsigned N    = 256,
  parameter int unsigned BUFW = 18
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  input  logic [3:0]  i_d,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic [11:0] o_coeff,
  output logic        o_coeff_valid,
  input  logic        i_coeff_ready,
  output logic [7:0]  o_idx,
  output logic        o_busy,
  output logic        o_done,
`ifdef DECOMPRESS_CTRL_BYPASS_EN
  output logic        o_err,
  input  logic        i_bypass
`else
  output logic        o_err
`endif
);

  localparam int unsigned CNTW = $clog2(BUFW + 1);
  localparam int unsigned NW   = $clog2(N + 1);
  localparam int unsigned BYW  = 9;
  localparam int unsigned PW   = 24;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [3:0]        d_q, d_d;
  logic [BUFW-1:0]   buf_q, buf_d;
  logic [CNTW-1:0]   bitcnt_q, bitcnt_d;
  logic [BYW-1:0]    bytes_q, bytes_d;
  logic [NW-1:0]     ext_q, ext_d;
  logic [11:0]       coeff_q, coeff_d;
  logic              valid_q, valid_d;
  logic [7:0]        idx_q, idx_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef DECOMPRESS_CTRL_BYPASS_EN
  logic              bypass_q, bypass_d;
`endif

  logic              legal_d, byte_ready_c, byte_acc, ext, hs, use_raw;
  logic [10:0]       x;
  logic [PW-1:0]     prod;
  logic [11:0]       dec;
  logic [BUFW-1:0]   buf_sh;
  logic [CNTW-1:0]   cnt_sh;

  // Datapath decode: handshakes, extraction and the rounding divide by 2^d
  always_comb begin
    legal_d      = i_d inside {4'd1, 4'd4, 4'd5, 4'd10, 4'd11};
    byte_ready_c = (state_q == RUN) && (bitcnt_q <= CNTW'(BUFW - 8))
                   && (bytes_q < (BYW'(d_q) << 5));
    byte_acc     = i_byte_valid && byte_ready_c;
    ext          = (state_q == RUN) && (bitcnt_q >= CNTW'(d_q))
                   && (!valid_q || i_coeff_ready) && (ext_q < NW'(N));
    hs           = valid_q && i_coeff_ready;
    x            = 11'(buf_q) & 11'((12'd1 << d_q) - 12'd1);
    prod         = PW'(x) * PW'(Q) + ((PW'(1) << d_q) >> 1);
    dec          = 12'(prod >> d_q);
`ifdef DECOMPRESS_CTRL_BYPASS_EN
    use_raw      = bypass_q;
`else
    use_raw      = 1'b0;
`endif
    buf_sh       = ext ? (buf_q >> d_q) : buf_q;
    cnt_sh       = ext ? (bitcnt_q - CNTW'(d_q)) : bitcnt_q;
  end

  // Next-state and register updates
  always_comb begin
    state_d  = state_q;
    d_d      = d_q;
    buf_d    = buf_q;
    bitcnt_d = bitcnt_q;
    bytes_d  = bytes_q;
    ext_d    = ext_q;
    coeff_d  = coeff_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
`ifdef DECOMPRESS_CTRL_BYPASS_EN
    bypass_d = bypass_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (legal_d) begin
            state_d  = RUN;
            d_d      = i_d;
            buf_d    = '0;
            bitcnt_d = '0;
            bytes_d  = '0;
            ext_d    = '0;
            valid_d  = 1'b0;
            idx_d    = '0;
`ifdef DECOMPRESS_CTRL_BYPASS_EN
            bypass_d = i_bypass;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        // A same-cycle byte lands just above the bits left after extraction
        if (byte_acc) begin
          buf_d    = buf_sh | (BUFW'(i_byte) << cnt_sh);
          bitcnt_d = cnt_sh + CNTW'(8);
          bytes_d  = bytes_q + BYW'(1);
        end else begin
          buf_d    = buf_sh;
          bitcnt_d = cnt_sh;
        end
        if (ext) begin
          valid_d = 1'b1;
          coeff_d = use_raw ? 12'(x) : dec;
          idx_d   = 8'(ext_q);
          ext_d   = ext_q + NW'(1);
        end else if (hs) begin
          valid_d = 1'b0;
          if (ext_q == NW'(N)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      d_q      <= '0;
      buf_q    <= '0;
      bitcnt_q <= '0;
      bytes_q  <= '0;
      ext_q    <= '0;
      coeff_q  <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef DECOMPRESS_CTRL_BYPASS_EN
      bypass_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      d_q      <= d_d;
      buf_q    <= buf_d;
      bitcnt_q <= bitcnt_d;
      bytes_q  <= bytes_d;
      ext_q    <= ext_d;
      coeff_q  <= coeff_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef DECOMPRESS_CTRL_BYPASS_EN
      bypass_q <= bypass_d;
`endif
    end
  end

  assign o_byte_ready  = byte_ready_c;
  assign o_coeff       = coeff_q;
  assign o_coeff_valid = valid_q;
  assign o_idx         = idx_q;
  assign o_busy        = (state_q == RUN);
  assign o_done        = done_q;
  assign o_err         = err_q;

endmodule
